// File: rtl/mem_read_arb.sv
// Two-port read arbiter (icache = port 0, dcache = port 1) in front of a single downstream read
// channel. Round-robin grant, one transaction at a time, with a watchdog that aborts a WAIT phase
// that goes TIMEOUT cycles without a beat.
module mem_read_arb #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [1:0]                 req_i,
  input  logic [1:0][ADDR_WIDTH-1:0] addr_i,
  output logic [1:0]                 rdy_o,
  output logic [1:0]                 rvalid_o,
  output logic [1:0]                 rlast_o,
  output logic [DATA_WIDTH-1:0]      rdata_o,
  output logic                       axi_rreq_o,
  output logic [ADDR_WIDTH-1:0]      axi_addr_o,
  input  logic                       axi_rdy_i,
  input  logic                       axi_rvalid_i,
  input  logic                       axi_rlast_i,
  input  logic [DATA_WIDTH-1:0]      axi_data_i,
  output logic                       timeout_o,
  output logic [1:0]                 grant_o
);

  localparam int unsigned WdogWidth = $clog2(TIMEOUT + 1);
  // Counter value at the start of the cycle in which it reaches TIMEOUT.
  localparam logic [WdogWidth-1:0] WdogLast = WdogWidth'(TIMEOUT - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StWait = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [1:0]            grant_q, grant_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  ptr_q, ptr_d;
  logic [WdogWidth-1:0]  wdog_q, wdog_d;

  logic win;
  logic beat;
  logic done;
  logic wdog_fire;
  logic accept;
  logic in_txn;

  // Qualified events of the current cycle.
  always_comb begin
    // Pointer only breaks ties; a lone requester always wins.
    win       = (req_i == 2'b11) ? ptr_q : req_i[1];
    in_txn    = (state_q == StReq) || (state_q == StWait);
    accept    = (state_q == StReq) && axi_rdy_i;
    beat      = (state_q == StWait) && axi_rvalid_i;
    done      = beat && axi_rlast_i;
    wdog_fire = (state_q == StWait) && !axi_rvalid_i && (wdog_q == WdogLast);
  end

  // Next-state logic for the arbiter FSM, owner, latched address, pointer and watchdog.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    ptr_d   = ptr_q;
    wdog_d  = wdog_q;
    case (state_q)
      StIdle: begin
        if (|req_i) begin
          grant_d = win ? 2'b10 : 2'b01;
          addr_d  = addr_i[win];
          ptr_d   = ~win;
          state_d = StReq;
        end
      end
      StReq: begin
        if (axi_rdy_i) begin
          wdog_d  = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        if (done || wdog_fire) begin
          grant_d = 2'b00;
          wdog_d  = '0;
          state_d = StIdle;
        end else if (axi_rvalid_i) begin
          wdog_d = '0;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      default: begin
        grant_d = 2'b00;
        wdog_d  = '0;
        state_d = StIdle;
      end
    endcase
  end

  // State registers; reset lands in IDLE with port 0 favoured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      grant_q <= 2'b00;
      addr_q  <= '0;
      ptr_q   <= 1'b0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      ptr_q   <= ptr_d;
      wdog_q  <= wdog_d;
    end
  end

  // Outputs are decoded from registered state, so reset clears them without a clock edge.
  always_comb begin
    grant_o    = grant_q;
    axi_rreq_o = in_txn && !wdog_fire;
    axi_addr_o = in_txn ? addr_q : '0;
    rdy_o      = accept ? grant_q : 2'b00;
    rvalid_o   = beat ? grant_q : 2'b00;
    rlast_o    = done ? grant_q : 2'b00;
    rdata_o    = beat ? axi_data_i : '0;
    timeout_o  = wdog_fire;
  end

endmodule

// File: doc/mem_read_arb.md
MEM_READ_ARB -- requirements
Module: mem_read_arb

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, request address width.
REQ-002 Parameter DATA_WIDTH, default 128, read beat width.
REQ-003 Parameter TIMEOUT, default 1024, maximum cycles in WAIT without a beat before abort; minimum 2.
REQ-004 clk  in  1  clock, all logic on the rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 req_i[1:0]  in  2  read request per port; port 0 is the icache, port 1 is the dcache; held high until that port's rlast_o.
REQ-007 addr_i[1:0]  in  2 x ADDR_WIDTH  request address per port, stable while req_i is high.
REQ-008 rdy_o[1:0]  out  2  one-cycle pulse: the request from this port has been accepted downstream.
REQ-009 rvalid_o[1:0]  out  2  read beat valid, routed to the granted port only.
REQ-010 rlast_o[1:0]  out  2  last beat of the granted transaction.
REQ-011 rdata_o  out  DATA_WIDTH  read beat data, shared by both ports and qualified by rvalid_o.
REQ-012 axi_rreq_o  out  1  downstream read request.
REQ-013 axi_addr_o  out  ADDR_WIDTH  downstream read address.
REQ-014 axi_rdy_i  in  1  downstream accepts the request when high while axi_rreq_o is high.
REQ-015 axi_rvalid_i, axi_rlast_i  in  1, 1  downstream beat valid and last-beat flag.
REQ-016 axi_data_i  in  DATA_WIDTH  downstream beat data.
REQ-017 timeout_o  out  1  one-cycle pulse: the granted transaction was aborted by the watchdog.
REQ-018 grant_o  out  2  one-hot register of the current owner; 0 when IDLE.

Function
REQ-019 The arbiter SHALL implement three states: IDLE, REQ and WAIT.
REQ-020 IDLE: if any req_i bit is set, select a winner, register grant_o and the winner's address, and move to REQ on the next edge.
REQ-021 Winner selection SHALL be round-robin via a 1-bit priority pointer; with a single requester, that requester wins.
REQ-022 The pointer SHALL point to the non-winner after every grant, so simultaneous requests alternate 0,1,0,1.
REQ-023 REQ: axi_rreq_o=1 and axi_addr_o=latched address; if axi_rdy_i=1, pulse rdy_o[owner] that cycle and move to WAIT.
REQ-024 WAIT: axi_rreq_o SHALL stay 1 and axi_addr_o SHALL stay the latched address until the transaction completes.
REQ-025 WAIT: rvalid_o[owner]=axi_rvalid_i, rlast_o[owner]=axi_rvalid_i&axi_rlast_i, and rdata_o=axi_data_i, all combinational with zero latency.
REQ-026 The non-owner's rvalid_o, rlast_o and rdy_o SHALL be 0 in every state.
REQ-027 WAIT with axi_rvalid_i&axi_rlast_i: clear grant_o and return to IDLE; a new grant is possible no earlier than the following cycle.
REQ-028 A watchdog counter, ceil(log2(TIMEOUT+1)) bits wide, SHALL clear on WAIT entry and on every beat, and increment on every other WAIT cycle.
REQ-029 When the watchdog reaches TIMEOUT: pulse timeout_o, drop axi_rreq_o, clear grant_o and return to IDLE without asserting rlast_o.
REQ-030 Beats arriving in IDLE or REQ SHALL be dropped and forwarded to no port.
REQ-031 Dropping req_i mid-transaction SHALL NOT abort it; the transaction runs to rlast or timeout.
REQ-032 The latched address and owner SHALL NOT change between grant and completion, regardless of addr_i or req_i activity.
REQ-033 Outside REQ and WAIT, axi_rreq_o=0 and axi_addr_o=0.
REQ-034 rdata_o SHALL be 0 whenever neither rvalid_o bit is set.

Reset
REQ-035 Asserting rst_n low SHALL immediately force: state=IDLE, grant_o=0, pointer=0 (port 0 first), watchdog=0, timeout_o=0, and all rdy_o/rvalid_o/rlast_o and axi_rreq_o/axi_addr_o to 0.
REQ-036 Reset mid-transaction SHALL abandon that transaction; the bench drives no further beats for it after reset release.

Verification
REQ-037 Single icache request: req_i=01, addr 0x1C00_0040, axi_rdy_i=1 one cycle after axi_rreq_o rises, one beat with rlast -> axi_addr_o=0x1C00_0040, rdy_o=01 pulse, rvalid_o=rlast_o=01 on the beat, IDLE next cycle.
REQ-038 Simultaneous requests held across four transactions: req_i=11 -> grant_o sequence 01,10,01,10 and each rdata_o routed only to its owner.
REQ-039 Backpressure: axi_rdy_i low for 5 cycles in REQ -> axi_rreq_o and axi_addr_o stable, no rdy_o pulse until axi_rdy_i=1.
REQ-040 Multi-beat: 4 beats, rlast on the 4th, with idle gaps -> four rvalid_o pulses, one rlast_o pulse, watchdog never fires.
REQ-041 Timeout: TIMEOUT=8, no beat after acceptance -> timeout_o pulses in the 8th WAIT cycle, grant_o=0, a pending req_i on the other port is granted afterwards.
REQ-042 Asynchronous reset asserted in WAIT between beats -> all outputs 0 without a clock edge; after release, req_i=10 gets port 1 immediately.
